lock_ctrl: RTL and testbench

- Password-entry controller for the keypad lock.
- Consumes decoded key presses, runs the lock state machine, and drives the six-digit seven-segment display driver directly.
- Each output slot is a 5-bit display code: digits 0x00–0x09, letters O/P/E/N/L/C/K/D/R as 0x10–0x18, blank 0x1F.
- Also drives the lock actuator enable.

---
 rtl/lock_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_lock_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_ctrl.sv
// Keypad password lock: entry FSM, shared state timer, display refresh and actuator enable.
// Optional failure lockout is built when LOCK_LOCKOUT_EN is defined.
module lock_ctrl #(
    parameter int          SEGMENT_NUM  = 6,
    parameter int          W_DATA       = 5,
    parameter logic [15:0] PASSWORD     = 16'h1234,
    parameter int unsigned OPEN_TIME    = 150_000_000,
    parameter int unsigned ERR_TIME     = 100_000_000,
    parameter int unsigned LOCKOUT_TIME = 1_500_000_000,
    parameter int unsigned MAX_FAIL     = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          key_vld,
    input  logic [3:0]                    key_num,
    output logic [SEGMENT_NUM*W_DATA-1:0] dout,
    output logic [SEGMENT_NUM-1:0]        dout_vld,
    output logic                          unlock
);

    localparam int DW = SEGMENT_NUM * W_DATA;

    // Timer is sized for the longest timed state so its width is build-independent.
    localparam int unsigned T_MAX0  = (OPEN_TIME > ERR_TIME) ? OPEN_TIME : ERR_TIME;
    localparam int unsigned T_MAX   = (LOCKOUT_TIME > T_MAX0) ? LOCKOUT_TIME : T_MAX0;
    localparam int          TIMER_W = $clog2(64'(T_MAX) + 64'd1);

    localparam logic [DW-1:0] DISP_LOCK = {5'h14, 5'h10, 5'h15, 5'h16, 5'h1F, 5'h1F};
    localparam logic [DW-1:0] DISP_OPEN = {5'h10, 5'h11, 5'h12, 5'h13, 5'h1F, 5'h1F};
    localparam logic [DW-1:0] DISP_ERR  = {5'h12, 5'h18, 5'h18, 5'h1F, 5'h1F, 5'h1F};
`ifdef LOCK_LOCKOUT_EN
    localparam logic [DW-1:0] DISP_LOCKED = {5'h14, 5'h10, 5'h15, 5'h16, 5'h12, 5'h17};
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INPUT   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_ERR     = 3'd3
`ifdef LOCK_LOCKOUT_EN
        , ST_LOCKOUT = 3'd4
`endif
    } state_t;

    state_t               state_r, state_s;
    logic [15:0]          entry_r, entry_s;
    logic [2:0]           count_r, count_s;
    logic [TIMER_W-1:0]   timer_r, timer_s;
    logic [DW-1:0]        dout_r, dout_s;
    logic [3:0]           refresh_r, refresh_s;
    logic [SEGMENT_NUM-1:0] dout_vld_r;
    logic                 unlock_r;

    logic is_digit_s, is_enter_s, is_clear_s;
    logic open_done_s, err_done_s;

    // Newest digit in slot 0, older digits to the left, unused slots blank.
    function automatic logic [DW-1:0] entry_disp(input logic [15:0] entry, input logic [2:0] count);
        logic [DW-1:0] d;
        d = {DW{1'b1}};
        for (int k = 0; k < 4; k++) begin
            if (k < int'(count)) begin
                d[k*W_DATA +: W_DATA] = W_DATA'(entry[k*4 +: 4]);
            end else begin
                d[k*W_DATA +: W_DATA] = {W_DATA{1'b1}};
            end
        end
        return d;
    endfunction

    assign is_digit_s  = key_vld && (key_num <= 4'd9);
    assign is_enter_s  = key_vld && (key_num == 4'd10);
    assign is_clear_s  = key_vld && (key_num == 4'd11);
    assign open_done_s = (timer_r == TIMER_W'(OPEN_TIME - 32'd1));
    assign err_done_s  = (timer_r == TIMER_W'(ERR_TIME - 32'd1));

`ifdef LOCK_LOCKOUT_EN
    logic [1:0] fail_r, fail_s;
    logic       lock_done_s;

    assign lock_done_s = (timer_r == TIMER_W'(LOCKOUT_TIME - 32'd1));

    // Consecutive-failure count: up on ERR entry, cleared by an open or a served lockout.
    always_comb begin
        if ((state_s == ST_ERR) && (state_r != ST_ERR)) begin
            fail_s = fail_r + 2'd1;
        end else if ((state_s == ST_OPEN) || ((state_r == ST_LOCKOUT) && (state_s != ST_LOCKOUT))) begin
            fail_s = 2'd0;
        end else begin
            fail_s = fail_r;
        end
    end

    // Fail counter register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            fail_r <= 2'd0;
        end else begin
            fail_r <= fail_s;
        end
    end
`endif

    // Next-state and entry register; timer expiry beats any key in the same cycle.
    always_comb begin
        state_s = state_r;
        entry_s = entry_r;
        count_s = count_r;
        case (state_r)
            ST_IDLE: begin
                if (is_digit_s) begin
                    entry_s = {12'h000, key_num};
                    count_s = 3'd1;
                    state_s = ST_INPUT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_INPUT: begin
                if (is_clear_s) begin
                    state_s = ST_IDLE;
                    count_s = 3'd0;
                end else if (is_enter_s) begin
                    count_s = 3'd0;
                    if ((count_r == 3'd4) && (entry_r == PASSWORD)) begin
                        state_s = ST_OPEN;
                    end else begin
                        state_s = ST_ERR;
                    end
                end else if (is_digit_s && (count_r < 3'd4)) begin
                    entry_s = {entry_r[11:0], key_num};
                    count_s = count_r + 3'd1;
                end else begin
                    state_s = ST_INPUT;
                end
            end
            ST_OPEN: begin
                if (open_done_s || is_enter_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OPEN;
                end
            end
            ST_ERR: begin
                if (err_done_s) begin
`ifdef LOCK_LOCKOUT_EN
                    if (fail_r == 2'(MAX_FAIL)) begin
                        state_s = ST_LOCKOUT;
                    end else begin
                        state_s = ST_IDLE;
                    end
`else
                    state_s = ST_IDLE;
`endif
                end else begin
                    state_s = ST_ERR;
                end
            end
`ifdef LOCK_LOCKOUT_EN
            ST_LOCKOUT: begin
                if (lock_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LOCKOUT;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
                count_s = 3'd0;
            end
        endcase
    end

    // Display content, refresh window and shared timer for the next cycle.
    always_comb begin
        dout_s = DISP_LOCK;
        case (state_s)
            ST_IDLE:    dout_s = DISP_LOCK;
            ST_INPUT:   dout_s = entry_disp(entry_s, count_s);
            ST_OPEN:    dout_s = DISP_OPEN;
            ST_ERR:     dout_s = DISP_ERR;
`ifdef LOCK_LOCKOUT_EN
            ST_LOCKOUT: dout_s = DISP_LOCKED;
`endif
            default:    dout_s = DISP_LOCK;
        endcase

        if (dout_s != dout_r) begin
            refresh_s = 4'd8;
        end else if (refresh_r != 4'd0) begin
            refresh_s = refresh_r - 4'd1;
        end else begin
            refresh_s = 4'd0;
        end

        if (state_s != state_r) begin
            timer_s = {TIMER_W{1'b0}};
        end else begin
            timer_s = timer_r + TIMER_W'(1);
        end
    end

    // State and output registers; reset preloads the refresh window.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r    <= ST_IDLE;
            entry_r    <= 16'h0000;
            count_r    <= 3'd0;
            timer_r    <= {TIMER_W{1'b0}};
            dout_r     <= DISP_LOCK;
            refresh_r  <= 4'd8;
            dout_vld_r <= {SEGMENT_NUM{1'b1}};
            unlock_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            entry_r    <= entry_s;
            count_r    <= count_s;
            timer_r    <= timer_s;
            dout_r     <= dout_s;
            refresh_r  <= refresh_s;
            dout_vld_r <= (refresh_s != 4'd0) ? {SEGMENT_NUM{1'b1}} : {SEGMENT_NUM{1'b0}};
            unlock_r   <= (state_s == ST_OPEN);
        end
    end

    assign dout     = dout_r;
    assign dout_vld = dout_vld_r;
    assign unlock   = unlock_r;

endmodule

// File: tb/tb_lock_ctrl.sv
// Randomized bench for lock_ctrl against a queue-based behavioural model of the lock rules.
// Works in both builds; the lockout rules are modelled when LOCK_LOCKOUT_EN is defined.
module tb_lock_ctrl;

    localparam int OPEN_T = 20;
    localparam int ERR_T  = 10;
    localparam int LOCK_T = 30;
`ifdef LOCK_LOCKOUT_EN
    localparam bit LOCKOUT_BUILD = 1'b1;
`else
    localparam bit LOCKOUT_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_vld;
    logic [3:0]  key_num;
    logic [29:0] dout;
    logic [5:0]  dout_vld;
    logic        unlock;

    int checks   = 0;
    int failures = 0;

    lock_ctrl #(
        .OPEN_TIME(OPEN_T),
        .ERR_TIME(ERR_T),
        .LOCKOUT_TIME(LOCK_T)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_vld(key_vld),
        .key_num(key_num),
        .dout(dout),
        .dout_vld(dout_vld),
        .unlock(unlock)
    );

    always #5 clk = ~clk;

    // Reference model state
    string       mode;
    int          digits[$];
    int          elapsed;
    int          fails;
    int          refresh_left;
    logic [29:0] exp_dout;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: observed=0x%0h expected=0x%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [29:0] display_of(input string m);
        int          s[6];
        logic [29:0] d;
        for (int k = 0; k < 6; k++) s[k] = 32'h1F;
        case (m)
            "IDLE":    begin s[5] = 32'h14; s[4] = 32'h10; s[3] = 32'h15; s[2] = 32'h16; end
            "INPUT":   for (int k = 0; k < digits.size(); k++) s[k] = digits[digits.size() - 1 - k];
            "OPEN":    begin s[5] = 32'h10; s[4] = 32'h11; s[3] = 32'h12; s[2] = 32'h13; end
            "ERR":     begin s[5] = 32'h12; s[4] = 32'h18; s[3] = 32'h18; end
            "LOCKOUT": begin
                s[5] = 32'h14; s[4] = 32'h10; s[3] = 32'h15;
                s[2] = 32'h16; s[1] = 32'h12; s[0] = 32'h17;
            end
            default: ;
        endcase
        d = 30'd0;
        for (int k = 0; k < 6; k++) d[5*k +: 5] = s[k][4:0];
        return d;
    endfunction

    task automatic model_reset();
        mode = "IDLE";
        digits.delete();
        elapsed = 0;
        fails = 0;
        refresh_left = 8;
        exp_dout = display_of("IDLE");
    endtask

    task automatic model_step(input logic v, input int n);
        string       nxt;
        int          limit;
        logic [29:0] nd;
        nxt = mode;
        limit = 0;
        if (mode == "OPEN") limit = OPEN_T;
        else if (mode == "ERR") limit = ERR_T;
        else if (mode == "LOCKOUT") limit = LOCK_T;

        if (limit != 0 && elapsed == limit - 1) begin
            if (mode == "ERR" && LOCKOUT_BUILD && fails >= 3) nxt = "LOCKOUT";
            else nxt = "IDLE";
            if (mode == "LOCKOUT") fails = 0;
        end else if (v) begin
            if (mode == "IDLE" && n <= 9) begin
                digits.delete();
                digits.push_back(n);
                nxt = "INPUT";
            end else if (mode == "INPUT") begin
                if (n <= 9 && digits.size() < 4) digits.push_back(n);
                else if (n == 11) nxt = "IDLE";
                else if (n == 10) begin
                    if (digits.size() == 4 && digits[0] == 1 && digits[1] == 2 &&
                        digits[2] == 3 && digits[3] == 4) nxt = "OPEN";
                    else nxt = "ERR";
                end
            end else if (mode == "OPEN" && n == 10) begin
                nxt = "IDLE";
            end
        end

        if (nxt == "ERR" && mode != "ERR") fails++;
        if (nxt == "OPEN") fails = 0;
        if (nxt != mode) elapsed = 0;
        else elapsed++;
        mode = nxt;

        nd = display_of(mode);
        if (nd != exp_dout) refresh_left = 8;
        else if (refresh_left > 0) refresh_left--;
        exp_dout = nd;
    endtask

    task automatic check_outputs(input string where);
        check_eq({where, ".dout"}, {2'b00, dout}, {2'b00, exp_dout});
        check_eq({where, ".dout_vld"}, {26'd0, dout_vld}, (refresh_left > 0) ? 32'h3F : 32'h0);
        check_eq({where, ".unlock"}, {31'd0, unlock}, (mode == "OPEN") ? 32'd1 : 32'd0);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cycle(input logic v, input logic [3:0] n);
        key_vld = v;
        key_num = n;
        @(posedge clk);
        model_step(v, int'(n));
        #1;
        check_outputs("cycle");
        @(negedge clk);
    endtask

    task automatic press(input int n);
        cycle(1'b1, 4'(n));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0);
    endtask

    task automatic code(input int a, input int b, input int c, input int d);
        press(a); press(b); press(c); press(d); press(10);
    endtask

    task automatic reset_and_release();
        rst_n = 1'b1;
        key_vld = 1'b0;
        key_num = 4'd0;
        repeat (3) @(negedge clk);
        model_reset();
        check_outputs("in_reset");
        rst_n = 1'b0;
        #1;
        check_outputs("release");
    endtask

    initial begin
        int pseq[5];
        int ptr;
        pseq[0] = 1; pseq[1] = 2; pseq[2] = 3; pseq[3] = 4; pseq[4] = 10;
        ptr = 0;

        reset_and_release();
        idle(10);

        code(1, 2, 3, 4);
        idle(25);

        code(1, 2, 3, 5);
        idle(12);
        press(1); press(2); press(10);
        idle(12);
        press(1); press(2); press(11);
        idle(3);
        press(10); press(11); press(12); press(15);
        idle(10);

        press(1); press(2); press(3); press(4);
        idle(10);
        press(9);
        idle(3);
        press(10);
        idle(4);
        press(10);
        idle(10);

        press(7); press(10);
        idle(9);
        press(5);
        idle(10);

        code(9, 9, 9, 9); idle(11);
        code(1, 2, 3, 5); idle(11);
        code(1, 2, 3, 4); idle(22);
        code(9, 9, 9, 9); idle(11);
        code(8, 8, 8, 8); idle(11);

        code(9, 9, 9, 9); idle(11);
        press(1); press(2); press(10);
        idle(5);
        press(1); press(10); press(3);
        idle(35);
        code(1, 2, 3, 4);
        idle(22);

        code(1, 2, 3, 4);
        idle(6);
        #2 rst_n = 1'b1;
        #1;
        model_reset();
        check_eq("async_reset.unlock", {31'd0, unlock}, 32'd0);
        check_eq("async_reset.dout", {2'b00, dout}, {2'b00, exp_dout});
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs("release2");
        idle(10);

        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 25) begin
                press(pseq[ptr]);
                ptr = (ptr + 1) % 5;
            end else if (r < 40) begin
                press($urandom_range(0, 15));
            end else begin
                idle(1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
